uart_byte_tx: RTL and testbench

UART_BYTE_TX -- requirements
Module: uart_byte_tx

---
 rtl/uart_byte_tx.sv | 153 +++++++++++++++
 tb/tb_uart_byte_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// One byte is accepted per strobe while idle; strobes during a frame are dropped.
module uart_byte_tx #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD      = 115200,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_din,
   input  logic       tx_din_vld,
   output logic       tx_busy,
   output logic       tx
);

   localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned BIT_W    = 3;

   // Configuration sanity checks, raised during elaboration
   if (BAUD_DIV < 2) begin : g_bad_baud_div
      $error("uart_byte_tx: BAUD_DIV=CLK_FREQ/BAUD must be at least 2");
   end
   if (PARITY > 2) begin : g_bad_parity
      $error("uart_byte_tx: PARITY must be 0, 1 or 2");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
      $error("uart_byte_tx: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   baud_q, baud_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               par_q, par_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               wrap_c;
   logic               par_bit_c;

   assign wrap_c    = (baud_q == CNT_W'(BAUD_DIV - 1));
   assign par_bit_c = (PARITY == 1) ? ~(^tx_din) : (^tx_din);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and next-output logic; tx_d is the value of the line for the next cycle
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;

      if (state_q != IDLE) begin
         baud_d = wrap_c ? '0 : baud_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            bit_d  = '0;
            if (tx_din_vld) begin
               state_d = START;
               shift_d = tx_din;
               par_d   = par_bit_c;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (wrap_c) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (wrap_c) begin
               if (bit_q == BIT_W'(7)) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     state_d = PAR;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
         PAR: begin
            if (wrap_c) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (wrap_c) begin
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // Combinational term blocks a second strobe on the acceptance edge
   assign tx_busy = busy_q | ((state_q == IDLE) & tx_din_vld);
   assign tx      = tx_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: five configurations on one clock, scoreboard of sent bytes.
module tb_uart_byte_tx;

   localparam int unsigned N    = 5;
   localparam int          DIV  = 434;
   localparam int          FDIV = 10;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    tx_a;
   logic [N-1:0]    busy_a;
   logic [N-1:0]    vld_a;
   logic [7:0]      din_a [N];

   int              total = 0;
   int              bad   = 0;
   int              cyc   = 0;
   logic [7:0]      sq [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_byte_tx u_def (
      .clk(clk), .rst_n(rst_n), .tx_din(din_a[0]), .tx_din_vld(vld_a[0]),
      .tx_busy(busy_a[0]), .tx(tx_a[0]));
   uart_byte_tx #(.PARITY(2)) u_even (
      .clk(clk), .rst_n(rst_n), .tx_din(din_a[1]), .tx_din_vld(vld_a[1]),
      .tx_busy(busy_a[1]), .tx(tx_a[1]));
   uart_byte_tx #(.PARITY(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .tx_din(din_a[2]), .tx_din_vld(vld_a[2]),
      .tx_busy(busy_a[2]), .tx(tx_a[2]));
   uart_byte_tx #(.STOP_BITS(2)) u_stop2 (
      .clk(clk), .rst_n(rst_n), .tx_din(din_a[3]), .tx_din_vld(vld_a[3]),
      .tx_busy(busy_a[3]), .tx(tx_a[3]));
   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) u_fast (
      .clk(clk), .rst_n(rst_n), .tx_din(din_a[4]), .tx_din_vld(vld_a[4]),
      .tx_busy(busy_a[4]), .tx(tx_a[4]));

   // Reference frame: bit 0 start, bits 8:1 data, then parity/stop; unused positions read as 1
   function automatic logic [11:0] model_frame(input logic [7:0] b, input int par_mode);
      logic [11:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = b;
      if (par_mode == 1) f[9] = ~(^b);
      if (par_mode == 2) f[9] = ^b;
      return f;
   endfunction

   // Strobe one byte; returns tx_busy seen during the strobe cycle; ends in frame cycle 0
   task automatic send(input int idx, input logic [7:0] b, output logic acc_busy);
      @(posedge clk); #1;
      din_a[idx] = b;
      vld_a[idx] = 1'b1;
      sq.push_back(b);
      #2 acc_busy = busy_a[idx];
      @(posedge clk); #1;
      vld_a[idx] = 1'b0;
      din_a[idx] = ~b;
   endtask

   // Observe a frame cycle by cycle; records each bit's first sample and any later change
   task automatic capture(input int idx, input int nbits, input int div,
                          output logic [11:0] bits, output int unstable, output int busy_cnt,
                          output logic busy_end, output logic tx_end);
      bits = '1; unstable = 0; busy_cnt = 0;
      for (int k = 0; k < nbits * div; k++) begin
         @(negedge clk);
         if (k % div == 0) bits[k / div] = tx_a[idx];
         else if (tx_a[idx] !== bits[k / div]) unstable++;
         if (busy_a[idx] === 1'b1) busy_cnt++;
      end
      @(negedge clk);
      busy_end = busy_a[idx];
      tx_end   = tx_a[idx];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      vld_a = '0;
      for (int i = 0; i < N; i++) din_a[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (tx_a !== 5'h1F) begin bad++; $display("FAIL reset_tx: got %b expected 11111", tx_a); end
      total++;
      if (busy_a !== 5'h00) begin bad++; $display("FAIL reset_busy: got %b expected 00000", busy_a); end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (tx_a !== 5'h1F || busy_a !== 5'h00) begin
         bad++; $display("FAIL idle_after_reset: tx=%b busy=%b expected 11111/00000", tx_a, busy_a);
      end
   endtask

   task automatic test_frame(input string name, input int idx, input logic [7:0] b,
                             input int par_mode, input int nbits);
      logic        ab, be, te;
      logic [11:0] bits, expf;
      int          uns, bc;
      logic [7:0]  exp_b;
      expf = model_frame(b, par_mode);
      send(idx, b, ab);
      capture(idx, nbits, DIV, bits, uns, bc, be, te);
      total++;
      if (ab !== 1'b1) begin bad++; $display("FAIL %s_accept_busy: got %b expected 1", name, ab); end
      total++;
      if (bits !== expf) begin bad++; $display("FAIL %s_bits: got %b expected %b", name, bits, expf); end
      total++;
      if (uns !== 0) begin bad++; $display("FAIL %s_hold: got %0d changes expected 0", name, uns); end
      total++;
      if (bc !== nbits * DIV) begin bad++; $display("FAIL %s_busy_len: got %0d expected %0d", name, bc, nbits * DIV); end
      total++;
      if (be !== 1'b0 || te !== 1'b1) begin
         bad++; $display("FAIL %s_end: busy=%b tx=%b expected 0/1", name, be, te);
      end
      total++;
      if (sq.size() == 0) begin
         bad++; $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
      end else begin
         exp_b = sq.pop_front();
         if (bits[8:1] !== exp_b) begin
            bad++; $display("FAIL %s_decode: got %h expected %h", name, bits[8:1], exp_b);
         end
      end
   endtask

   task automatic test_parity_bits();
      logic        ab, be, te;
      logic [11:0] bits;
      int          uns, bc;
      send(1, 8'h31, ab);
      capture(1, 11, DIV, bits, uns, bc, be, te);
      void'(sq.pop_front());
      total++;
      if (bits[9] !== 1'b1) begin bad++; $display("FAIL even_par_bit: got %b expected 1", bits[9]); end
      send(2, 8'h31, ab);
      capture(2, 11, DIV, bits, uns, bc, be, te);
      void'(sq.pop_front());
      total++;
      if (bits[9] !== 1'b0) begin bad++; $display("FAIL odd_par_bit: got %b expected 0", bits[9]); end
   endtask

   task automatic test_drop_while_busy();
      logic        ab, be, te;
      logic [11:0] bits;
      int          uns, bc, zeros;
      logic [7:0]  exp_b;
      send(0, 8'hA5, ab);
      fork
         capture(0, 10, DIV, bits, uns, bc, be, te);
         begin
            repeat (1000) @(posedge clk);
            #1;
            din_a[0] = 8'h00;
            vld_a[0] = 1'b1;
            @(posedge clk); #1;
            vld_a[0] = 1'b0;
         end
      join
      zeros = 0;
      for (int k = 0; k < 2 * DIV; k++) begin
         @(negedge clk);
         if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0) zeros++;
      end
      total++;
      if (bits !== model_frame(8'hA5, 0)) begin bad++; $display("FAIL drop_bits: got %b expected %b", bits, model_frame(8'hA5, 0)); end
      total++;
      if (uns !== 0 || bc !== 10 * DIV) begin
         bad++; $display("FAIL drop_frame: changes=%0d busy=%0d expected 0/%0d", uns, bc, 10 * DIV);
      end
      total++;
      if (zeros !== 0) begin bad++; $display("FAIL drop_no_second_frame: got %0d active cycles expected 0", zeros); end
      exp_b = sq.pop_front();
      total++;
      if (bits[8:1] !== exp_b) begin bad++; $display("FAIL drop_decode: got %h expected %h", bits[8:1], exp_b); end
   endtask

   task automatic test_reset_mid_frame();
      logic        ab;
      logic [11:0] expf;
      expf = model_frame(8'h12, 0);
      send(0, 8'h12, ab);
      repeat (2000) @(posedge clk);
      #1;
      total++;
      if (tx_a[0] !== expf[2000 / DIV]) begin
         bad++; $display("FAIL mid_frame_tx: got %b expected %b", tx_a[0], expf[2000 / DIV]);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin
         bad++; $display("FAIL async_reset: tx=%b busy=%b expected 1/0", tx_a[0], busy_a[0]);
      end
      sq.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      test_frame("after_reset", 0, 8'h3A, 0, 10);
   endtask

   task automatic test_back_to_back();
      logic [7:0] list [19];
      int         decoded;
      for (int i = 0; i < 19; i++) list[i] = 8'($urandom_range(0, 255));
      decoded = 0;
      fork
         begin : driver
            for (int i = 0; i < 19; i++) begin
               int w;
               w = 0;
               while (busy_a[4] !== 1'b0 && w < 500) begin
                  @(posedge clk); #1;
                  w++;
               end
               if (w >= 500) begin
                  total++; bad++;
                  $display("FAIL b2b_driver_timeout: byte %0d never saw tx_busy low", i);
                  break;
               end
               din_a[4] = list[i];
               vld_a[4] = 1'b1;
               sq.push_back(list[i]);
               @(posedge clk); #1;
               vld_a[4] = 1'b0;
            end
         end
         begin : monitor
            int         last, start, w;
            logic [7:0] d;
            last = -1;
            for (int n = 0; n < 19; n++) begin
               w = 0;
               @(negedge clk);
               while (tx_a[4] !== 1'b0 && w < 1000) begin
                  @(negedge clk);
                  w++;
               end
               if (w >= 1000) begin
                  total++; bad++;
                  $display("FAIL b2b_monitor_timeout: frame %0d never started", n);
                  break;
               end
               start = cyc;
               if (last >= 0) begin
                  total++;
                  if (start - last < 10 * FDIV || start - last > 10 * FDIV + 1) begin
                     bad++; $display("FAIL b2b_gap: got spacing %0d expected %0d..%0d", start - last, 10 * FDIV, 10 * FDIV + 1);
                  end
               end
               last = start;
               repeat (FDIV / 2) @(negedge clk);
               total++;
               if (tx_a[4] !== 1'b0) begin bad++; $display("FAIL b2b_start_bit: got %b expected 0", tx_a[4]); end
               for (int b = 0; b < 8; b++) begin
                  repeat (FDIV) @(negedge clk);
                  d[b] = tx_a[4];
               end
               repeat (FDIV) @(negedge clk);
               total++;
               if (tx_a[4] !== 1'b1) begin bad++; $display("FAIL b2b_stop_bit: got %b expected 1", tx_a[4]); end
               total++;
               if (sq.size() == 0) begin
                  bad++; $display("FAIL b2b_scoreboard: got %h with empty queue", d);
               end else if (d !== sq[0]) begin
                  bad++; $display("FAIL b2b_decode: got %h expected %h", d, sq[0]);
                  void'(sq.pop_front());
               end else begin
                  void'(sq.pop_front());
               end
               decoded++;
            end
         end
      join
      total++;
      if (decoded !== 19 || sq.size() !== 0) begin
         bad++; $display("FAIL b2b_count: decoded=%0d left=%0d expected 19/0", decoded, sq.size());
      end
   endtask

   initial begin
      test_reset();
      test_frame("basic_55", 0, 8'h55, 0, 10);
      test_frame("even_31", 1, 8'h31, 2, 11);
      test_frame("odd_31", 2, 8'h31, 1, 11);
      test_parity_bits();
      test_frame("stop2_ff", 3, 8'hFF, 0, 11);
      test_drop_while_busy();
      test_reset_mid_frame();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
